// File: rtl/nfc_way_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nfc_way_arbiter
// Description : Round-robin arbiter granting the shared NAND DQ bus to one way,
//               with post-release guard cycles. Optional grant watchdog enabled
//               by defining NFC_WAY_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nfc_way_arbiter #(
    parameter int NumberOfWays  = 4,
    parameter int GuardCycles   = 2,
    parameter int TimeoutCycles = 4096
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [NumberOfWays-1:0] iWayRequest,
    input  logic [NumberOfWays-1:0] iWayRelease,
    input  logic [NumberOfWays-1:0] iReadyBusy,
    output logic [NumberOfWays-1:0] oWayGrant,
    output logic                    oGrantValid,
    output logic [2:0]              oGrantIndex,
    output logic                    oBusIdle,
    output logic                    oTimeout
);

    if (NumberOfWays < 2 || NumberOfWays > 8 || GuardCycles < 0 || GuardCycles > 15 ||
        TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_param_check
        $error("nfc_way_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t                  state_q;
    logic [2:0]              ptr_q;
    logic [3:0]              guard_q;
    logic [NumberOfWays-1:0] grant_q;
    logic                    valid_q;
    logic [2:0]              index_q;
    logic                    idle_q;

    logic [7:0]              w_eligible;
    logic [3:0]              w_cand;
    logic                    w_sel_found;
    logic [2:0]              w_sel_idx;
    logic [NumberOfWays-1:0] w_sel_onehot;
    logic                    w_release;
    logic [2:0]              w_ptr_next;
    logic                    w_wdog_hit;

    assign w_eligible = 8'(iWayRequest & iReadyBusy);

    // Rotating priority search: first eligible way at or above the pointer.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 3'd0;
        w_cand      = 4'd0;
        for (int k = 0; k < NumberOfWays; k++) begin
            w_cand = 4'(ptr_q) + 4'(k);
            if (w_cand >= 4'(NumberOfWays)) begin
                w_cand = w_cand - 4'(NumberOfWays);
            end
            if (!w_sel_found && w_eligible[w_cand[2:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand[2:0];
            end
        end
    end

    assign w_sel_onehot = {{(NumberOfWays-1){1'b0}}, 1'b1} << w_sel_idx;
    // A dropped request from the owner counts as a release.
    assign w_release    = |(grant_q & (iWayRelease | ~iWayRequest));
    assign w_ptr_next   = (index_q == 3'(NumberOfWays - 1)) ? 3'd0 : index_q + 3'd1;

`ifdef NFC_WAY_ARB_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        timeout_q;

    assign w_wdog_hit = (state_q == ST_HOLD) && (wdog_q == 16'(TimeoutCycles - 1));

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            wdog_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= w_wdog_hit && !w_release;
            if (state_q == ST_HOLD && !w_release && !w_wdog_hit) begin
                wdog_q <= wdog_q + 16'd1;
            end else begin
                wdog_q <= 16'd0;
            end
        end
    end

    assign oTimeout = timeout_q;
`else
    assign w_wdog_hit = 1'b0;
    assign oTimeout   = 1'b0;
`endif

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            guard_q <= 4'd0;
            grant_q <= '0;
            valid_q <= 1'b0;
            index_q <= 3'd0;
            idle_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        grant_q <= w_sel_onehot;
                        valid_q <= 1'b1;
                        index_q <= w_sel_idx;
                        idle_q  <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_release || w_wdog_hit) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= w_ptr_next;
                        if (GuardCycles == 0) begin
                            idle_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            guard_q <= 4'(GuardCycles - 1);
                            state_q <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_q == 4'd0) begin
                        idle_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        guard_q <= guard_q - 4'd1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign oWayGrant   = grant_q;
    assign oGrantValid = valid_q;
    assign oGrantIndex = index_q;
    assign oBusIdle    = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_nfc_way_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nfc_way_arbiter
// Description : Directed and randomized self-checking bench for nfc_way_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nfc_way_arbiter;

    localparam int N = 4;
    localparam int G = 2;
    localparam int T = 16;
`ifdef NFC_WAY_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] rel = '0;
    logic [N-1:0] rdy = '1;
    logic [N-1:0] oWayGrant;
    logic         oGrantValid;
    logic [2:0]   oGrantIndex;
    logic         oBusIdle;
    logic         oTimeout;

    int cmp_count  = 0;
    int fail_count = 0;

    nfc_way_arbiter #(
        .NumberOfWays (N),
        .GuardCycles  (G),
        .TimeoutCycles(T)
    ) dut (
        .iSystemClock(clk),
        .iReset      (rst),
        .iWayRequest (req),
        .iWayRelease (rel),
        .iReadyBusy  (rdy),
        .oWayGrant   (oWayGrant),
        .oGrantValid (oGrantValid),
        .oGrantIndex (oGrantIndex),
        .oBusIdle    (oBusIdle),
        .oTimeout    (oTimeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner plus a timestamp for when arbitration may resume.
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_resume = 0;
    int m_age    = 0;
    int m_idx    = 0;
    int m_cyc    = 0;
    bit m_to     = 1'b0;
    bit m_idle   = 1'b1;

    always @(posedge clk) begin : p_model
        int owner, ptr, resume, age, idx, w;
        bit to, found;
        owner = m_owner; ptr = m_ptr; resume = m_resume; age = m_age; idx = m_idx;
        to = 1'b0; found = 1'b0;
        if (rst) begin
            owner = -1; ptr = 0; resume = 0; age = 0; idx = 0;
        end else if (owner >= 0) begin
            age = age + 1;
            if (rel[owner] || !req[owner]) begin
                ptr = (owner + 1) % N; owner = -1; resume = m_cyc + G + 1; age = 0;
            end else if (TO_EN && age == T) begin
                ptr = (owner + 1) % N; owner = -1; resume = m_cyc + G + 1; age = 0;
                to = 1'b1;
            end
        end else if (m_cyc >= resume) begin
            for (int k = 0; k < N; k++) begin
                w = (ptr + k) % N;
                if (!found && req[w] && rdy[w]) begin
                    found = 1'b1; owner = w; idx = w; age = 0;
                end
            end
        end
        m_owner  <= owner;
        m_ptr    <= ptr;
        m_resume <= resume;
        m_age    <= age;
        m_idx    <= idx;
        m_to     <= to;
        m_idle   <= (owner < 0) && (m_cyc + 1 >= resume);
        m_cyc    <= m_cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; rel = '0; rdy = '1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; rdy = 4'b1111; rel = '0;
        step(2);
        cmp_count++; if (oWayGrant !== 4'b0000) begin fail_count++; $display("FAIL reset_grant: got %b expected %b", oWayGrant, 4'b0000); end
        cmp_count++; if (oGrantValid !== 1'b0) begin fail_count++; $display("FAIL reset_valid: got %b expected 0", oGrantValid); end
        cmp_count++; if (oGrantIndex !== 3'd0) begin fail_count++; $display("FAIL reset_index: got %0d expected 0", oGrantIndex); end
        cmp_count++; if (oBusIdle !== 1'b1) begin fail_count++; $display("FAIL reset_idle: got %b expected 1", oBusIdle); end
        cmp_count++; if (oTimeout !== 1'b0) begin fail_count++; $display("FAIL reset_timeout: got %b expected 0", oTimeout); end
        rst = 1'b0; req = 4'b0110;
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0010 || oGrantIndex !== 3'd1) begin fail_count++; $display("FAIL first_grant_lowest: got %b/%0d expected 0010/1", oWayGrant, oGrantIndex); end
    endtask

    task automatic test_basic();
        apply_reset();
        req = 4'b0101; rdy = 4'b1111;
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0001 || oGrantValid !== 1'b1 || oBusIdle !== 1'b0) begin fail_count++; $display("FAIL basic_grant0: got %b v=%b idle=%b expected 0001 v=1 idle=0", oWayGrant, oGrantValid, oBusIdle); end
        rel = 4'b0001;
        step(1);
        rel = '0;
        cmp_count++; if (oWayGrant !== 4'b0000 || oBusIdle !== 1'b0 || oGrantIndex !== 3'd0) begin fail_count++; $display("FAIL basic_guard1: got %b idle=%b idx=%0d expected 0000 idle=0 idx=0", oWayGrant, oBusIdle, oGrantIndex); end
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0000 || oBusIdle !== 1'b0) begin fail_count++; $display("FAIL basic_guard2: got %b idle=%b expected 0000 idle=0", oWayGrant, oBusIdle); end
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0000 || oBusIdle !== 1'b1) begin fail_count++; $display("FAIL basic_idle: got %b idle=%b expected 0000 idle=1", oWayGrant, oBusIdle); end
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0100 || oGrantIndex !== 3'd2) begin fail_count++; $display("FAIL basic_grant2: got %b/%0d expected 0100/2", oWayGrant, oGrantIndex); end
    endtask

    task automatic test_rotation();
        int nogrant, guard, expw;
        apply_reset();
        req = 4'b1111; rdy = 4'b1111;
        step(1);
        for (int g = 0; g < 5; g++) begin
            nogrant = 0; guard = 0;
            while (!oGrantValid && nogrant < 20) begin
                nogrant++;
                if (!oBusIdle) guard++;
                step(1);
            end
            expw = g % N;
            cmp_count++; if (oWayGrant !== 4'(1 << expw)) begin fail_count++; $display("FAIL rotation_order[%0d]: got %b expected %b", g, oWayGrant, 4'(1 << expw)); end
            if (g > 0) begin
                cmp_count++; if (guard != G || nogrant != G + 1) begin fail_count++; $display("FAIL rotation_gap[%0d]: got guard=%0d nogrant=%0d expected %0d/%0d", g, guard, nogrant, G, G + 1); end
            end
            step(4);
            rel = 4'(1 << expw);
            step(1);
            rel = '0;
        end
    endtask

    task automatic test_ready_gate();
        apply_reset();
        req = 4'b0010; rdy = 4'b1101;
        step(3);
        cmp_count++; if (oWayGrant !== 4'b0000 || oGrantValid !== 1'b0) begin fail_count++; $display("FAIL busy_no_grant: got %b v=%b expected 0000 v=0", oWayGrant, oGrantValid); end
        rdy = 4'b1111;
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0010 || oGrantIndex !== 3'd1) begin fail_count++; $display("FAIL ready_grant: got %b/%0d expected 0010/1", oWayGrant, oGrantIndex); end
    endtask

    task automatic test_foreign_release_and_reset();
        rel = 4'b1000; rdy = 4'b0000;
        step(1);
        rel = '0;
        step(2);
        cmp_count++; if (oWayGrant !== 4'b0010 || oGrantValid !== 1'b1) begin fail_count++; $display("FAIL foreign_release_held: got %b v=%b expected 0010 v=1", oWayGrant, oGrantValid); end
        rdy = 4'b1111; rst = 1'b1;
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0000 || oGrantValid !== 1'b0 || oGrantIndex !== 3'd0 || oBusIdle !== 1'b1) begin fail_count++; $display("FAIL midhold_reset: got %b v=%b idx=%0d idle=%b expected 0000 v=0 idx=0 idle=1", oWayGrant, oGrantValid, oGrantIndex, oBusIdle); end
        rst = 1'b0;
    endtask

    task automatic test_watchdog();
        int early_to;
        apply_reset();
        req = 4'b0100; rdy = 4'b1111;
        step(1);
        early_to = 0;
`ifdef NFC_WAY_ARB_TIMEOUT_EN
        for (int i = 0; i < T - 1; i++) begin
            step(1);
            if (oTimeout !== 1'b0) early_to++;
        end
        cmp_count++; if (oWayGrant !== 4'b0100 || early_to != 0) begin fail_count++; $display("FAIL wdog_hold: got %b early_pulses=%0d expected 0100 and 0", oWayGrant, early_to); end
        step(1);
        cmp_count++; if (oWayGrant !== 4'b0000 || oTimeout !== 1'b1) begin fail_count++; $display("FAIL wdog_fire: got %b to=%b expected 0000 to=1", oWayGrant, oTimeout); end
        step(1);
        cmp_count++; if (oTimeout !== 1'b0) begin fail_count++; $display("FAIL wdog_pulse_width: got %b expected 0", oTimeout); end
`else
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (oTimeout !== 1'b0 || oWayGrant !== 4'b0100) early_to++;
        end
        cmp_count++; if (oWayGrant !== 4'b0100 || early_to != 0) begin fail_count++; $display("FAIL no_wdog_hold: got %b bad_cycles=%0d expected 0100 and 0", oWayGrant, early_to); end
`endif
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
                rdy[b] = ($urandom_range(0, 7) != 0);
            end
            rel = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, N - 1)) : 4'b0000;
            rst = ($urandom_range(0, 199) == 0);
            step(1);
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            cmp_count++; if (oWayGrant !== eg) begin fail_count++; $display("FAIL rand_grant@%0d: got %b expected %b", c, oWayGrant, eg); end
            cmp_count++; if (oGrantValid !== (m_owner >= 0)) begin fail_count++; $display("FAIL rand_valid@%0d: got %b expected %b", c, oGrantValid, (m_owner >= 0)); end
            cmp_count++; if (oGrantIndex !== 3'(m_idx)) begin fail_count++; $display("FAIL rand_index@%0d: got %0d expected %0d", c, oGrantIndex, m_idx); end
            cmp_count++; if (oBusIdle !== m_idle) begin fail_count++; $display("FAIL rand_idle@%0d: got %b expected %b", c, oBusIdle, m_idle); end
            cmp_count++; if (oTimeout !== m_to) begin fail_count++; $display("FAIL rand_timeout@%0d: got %b expected %b", c, oTimeout, m_to); end
        end
        rst = 1'b0; rel = '0;
    endtask

    initial begin
        step(1);
        test_reset();
        test_basic();
        test_rotation();
        test_ready_gate();
        test_foreign_release_and_reset();
        test_watchdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
`default_nettype wire
